aes_out_collector: RTL

- Downstream of the AES-128 cipher top. Consumes the cipher's serial ciphertext stream (DOUT qualified by OUT_VAL) and reassembles 128-bit blocks.
- Buffers up to two complete blocks in a ping-pong store.
- Drains blocks as bytes over a valid/ready stream toward the host/UART side.
- Decouples the fixed-rate serial cipher output from a host that may apply backpressure.

---
 rtl/aes_pkg.sv | 7 +
 rtl/aes_blk_fifo.sv | 36 +++
 rtl/aes_out_collector.sv | 85 ++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared sizing for the AES output path: block width, byte width and byte-index width.
package aes_pkg;
   localparam int AES_BLK_W  = 128;
   localparam int AES_BYTE_W = 8;
   localparam int AES_NBYTES = AES_BLK_W / AES_BYTE_W;
   localparam int AES_IDX_W  = (AES_NBYTES > 1) ? $clog2(AES_NBYTES) : 1;
endpackage

// File: rtl/aes_blk_fifo.sv
// Two-entry block FIFO (ping-pong store). The caller guarantees push only when not full
// or popping, and pop only when non-empty.
module aes_blk_fifo #(
   parameter int BLK_W = 128
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [BLK_W-1:0] din,
   input  logic             pop,
   output logic [1:0]       occ,
   output logic [BLK_W-1:0] head
);
   logic [BLK_W-1:0] mem [2];
   logic             wr_ptr;
   logic             rd_ptr;

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         occ    <= 2'd0;
      end else begin
         if (push) wr_ptr <= ~wr_ptr;
         if (pop)  rd_ptr <= ~rd_ptr;
         occ <= occ + {1'b0, push} - {1'b0, pop};
      end
   end

   // Storage needs no reset; nothing is visible until occ says so.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= din;
   end

   assign head = mem[rd_ptr];
endmodule

// File: rtl/aes_out_collector.sv
// Reassembles the serial AES ciphertext into blocks and drains them as bytes over valid/ready.
// Optional block counter port blk_cnt is enabled by defining AES_OUT_CNT_EN.
module aes_out_collector
   import aes_pkg::*;
#(
   parameter int BLK_W = AES_BLK_W,
   parameter int OUT_W = AES_BYTE_W,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             dout_bit,
   input  logic             out_val,
   output logic [OUT_W-1:0] m_data,
   output logic             m_valid,
   input  logic             m_ready,
   output logic             m_last,
   output logic             overflow,
   input  logic             clr_ovf
`ifdef AES_OUT_CNT_EN
   ,
   output logic [CNT_W-1:0] blk_cnt
`endif
);
   localparam int NB    = BLK_W / OUT_W;
   localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
   localparam int CW    = $clog2(BLK_W);
   localparam logic [CW-1:0]    LAST_BIT = CW'(BLK_W - 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB - 1);

   logic [BLK_W-2:0] shreg;
   logic [CW-1:0]    bit_cnt;
   logic [IDX_W-1:0] idx;
   logic [1:0]       occ;
   logic [BLK_W-1:0] head;
   logic             complete, push, pop, drop, xfer;

   assign complete = out_val && (bit_cnt == LAST_BIT);
   assign xfer     = m_valid && m_ready;
   assign pop      = xfer && m_last;
   // A full store still accepts a block when the head leaves on the same edge.
   assign push     = complete && ((occ != 2'd2) || pop);
   assign drop     = complete && (occ == 2'd2) && !pop;

   always_ff @(posedge clk) begin
      if (reset) begin
         shreg    <= '0;
         bit_cnt  <= '0;
         idx      <= '0;
         overflow <= 1'b0;
      end else begin
         if (out_val) begin
            shreg   <= {shreg[BLK_W-3:0], dout_bit};
            bit_cnt <= complete ? '0 : bit_cnt + CW'(1);
         end
         if (xfer) idx <= m_last ? '0 : idx + IDX_W'(1);
         if (drop)         overflow <= 1'b1;
         else if (clr_ovf) overflow <= 1'b0;
      end
   end

   aes_blk_fifo #(.BLK_W(BLK_W)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .din   ({shreg, dout_bit}),
      .pop   (pop),
      .occ   (occ),
      .head  (head)
   );

   assign m_valid = (occ != 2'd0);
   assign m_last  = m_valid && (idx == LAST_IDX);
   assign m_data  = m_valid ? head[(NB - 1 - int'(idx)) * OUT_W +: OUT_W] : '0;

`ifdef AES_OUT_CNT_EN
   always_ff @(posedge clk) begin
      if (reset)     blk_cnt <= '0;
      else if (push) blk_cnt <= blk_cnt + CNT_W'(1);
   end
`else
   logic [CNT_W-1:0] unused_cnt;
   assign unused_cnt = '0;
`endif
endmodule
